// File: rtl/alu_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mult_sequencer
// Brief    : Shift-and-add 32x32->64 multiplier that borrows the shared ALU
//            adder, one bit per cycle; result exposed as MIPS-style hi/lo.
//            Optional signed support via `define MULT_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mult_sequencer #(
   parameter int         WIDTH   = 32,
   parameter logic [2:0] OP_ADD  = 3'd2,
   parameter logic [2:0] OP_IDLE = 3'd0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0] mplier,
   input  logic             sgn,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_res,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int                 c_cnt_w = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_run  = 2'd1;
`ifdef MULT_SIGNED_EN
   localparam logic [1:0] c_fix  = 2'd2;
`endif
   localparam logic [1:0] c_done = 2'd3;

   logic [1:0]         r_state;
   logic [1:0]         w_next;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_mreg;
   logic [c_cnt_w-1:0] r_count;
   logic               w_accept;
   logic               w_last;
   logic               w_carry;
   logic [WIDTH-1:0]   w_mcand_ld;
   logic [WIDTH-1:0]   w_mplier_ld;

   assign w_accept = start && ((r_state == c_idle) || (r_state == c_done));
   assign w_last   = (r_count == c_last);
   // The adder wrapped iff the sum fell below the old partial product.
   assign w_carry  = (alu_res < r_hi);
   assign hi       = r_hi;
   assign lo       = r_lo;

`ifdef MULT_SIGNED_EN
   logic r_neg;
   logic w_neg_ld;

   always_comb begin
      w_mcand_ld  = (sgn && mcand[WIDTH-1])  ? -mcand  : mcand;
      w_mplier_ld = (sgn && mplier[WIDTH-1]) ? -mplier : mplier;
      w_neg_ld    = sgn && (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
   end
`else
   logic w_unused_sgn;

   assign w_unused_sgn = sgn;
   assign w_mcand_ld   = mcand;
   assign w_mplier_ld  = mplier;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle: if (w_accept) w_next = c_run;
         c_run: begin
            if (w_last) begin
`ifdef MULT_SIGNED_EN
               w_next = c_fix;
`else
               w_next = c_done;
`endif
            end
         end
`ifdef MULT_SIGNED_EN
         c_fix:  w_next = c_done;
`endif
         c_done: w_next = w_accept ? c_run : c_idle;
         default: w_next = c_idle;
      endcase
   end

   always_comb begin
      busy   = 1'b0;
      done   = 1'b0;
      alu_a  = '0;
      alu_b  = '0;
      alu_op = OP_IDLE;
      case (r_state)
         c_run: begin
            busy   = 1'b1;
            alu_a  = r_hi;
            alu_b  = r_lo[0] ? r_mreg : '0;
            alu_op = OP_ADD;
         end
`ifdef MULT_SIGNED_EN
         c_fix:  busy = 1'b1;
`endif
         c_done: done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi    <= '0;
         r_lo    <= '0;
         r_mreg  <= '0;
         r_count <= '0;
`ifdef MULT_SIGNED_EN
         r_neg   <= 1'b0;
`endif
      end else if (w_accept) begin
         r_hi    <= '0;
         r_lo    <= w_mplier_ld;
         r_mreg  <= w_mcand_ld;
         r_count <= '0;
`ifdef MULT_SIGNED_EN
         r_neg   <= w_neg_ld;
`endif
      end else if (r_state == c_run) begin
         {r_hi, r_lo} <= {w_carry, alu_res, r_lo[WIDTH-1:1]};
         r_count      <= r_count + 1'b1;
      end
`ifdef MULT_SIGNED_EN
      else if ((r_state == c_fix) && r_neg) begin
         {r_hi, r_lo} <= -{r_hi, r_lo};
      end
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mult_sequencer
// Brief    : Directed scoreboard bench for alu_mult_sequencer with an ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mult_sequencer;

   localparam int W = 32;
`ifdef MULT_SIGNED_EN
   localparam int LAT = W + 2;
`else
   localparam int LAT = W + 1;
`endif

   logic         clk = 1'b0;
   logic         reset, start, sgn;
   logic [W-1:0] mcand, mplier, alu_a, alu_b, alu_res, hi, lo, junk;
   logic [2:0]   alu_op;
   logic         busy, done;

   typedef struct {
      logic [63:0] prod;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc, busyc, op_bad, seen;
   logic [63:0] last_prod;

   always #5 clk = ~clk;

   // Shared ALU: adds when asked, otherwise shows unrelated datapath traffic.
   assign alu_res = (alu_op == 3'd2) ? alu_a + alu_b : junk;

   alu_mult_sequencer dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .mcand   (mcand),
      .mplier  (mplier),
      .sgn     (sgn),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_op  (alu_op),
      .alu_res (alu_res),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [63:0] r;
      r = {32'b0, a} * {32'b0, b};
`ifdef MULT_SIGNED_EN
      if (sgn) begin
         logic signed [63:0] sa, sb2;
         sa  = {{32{a[W-1]}}, a};
         sb2 = {{32{b[W-1]}}, b};
         r   = sa * sb2;
      end
`endif
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (busy) busyc++;
      if (busy && cyc <= W && alu_op !== 3'd2) op_bad++;
      junk = $urandom;
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
      exp_t e;
      mcand  = a;
      mplier = b;
      sgn    = s;
      start  = 1'b1;
      if (push) begin
         e.prod = model(a, b);
         e.lat  = LAT;
         sb.push_back(e);
      end
      cyc    = 0;
      busyc  = 0;
      op_bad = 0;
      step();
      start  = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      exp_t e;
      while (!done && cyc < 100) step();
      check({tag, "_done"}, 64'(done), 64'd1);
      if (sb.size() == 0) begin
         check({tag, "_sb_entry"}, 64'd0, 64'd1);
         return;
      end
      e = sb.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e.prod[63:32]));
      check({tag, "_lo"}, 64'(lo), 64'(e.prod[31:0]));
      check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
      check({tag, "_busy_cycles"}, 64'(busyc), 64'(e.lat - 1));
      check({tag, "_run_op_add"}, 64'(op_bad), 64'd0);
      last_prod = e.prod;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; sgn = 1'b0;
      mcand = '0; mplier = '0; junk = '0;
      cyc = 0; busyc = 0; op_bad = 0; seen = 0; last_prod = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_alu_a", 64'(alu_a), 64'd0);
      check("rst_alu_b", 64'(alu_b), 64'd0);
      check("rst_alu_op", 64'(alu_op), 64'd0);

      issue(32'd100, 32'd200, 1'b0, 1'b1);
      wait_done("basic");
      step();

      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
      wait_done("carry");

      issue(32'h1234_5678, 32'd0, 1'b0, 1'b1);
      wait_done("zero");
      issue(32'd7, 32'd6, 1'b0, 1'b1);
      wait_done("b2b");
      step();

      issue(32'd5, 32'd5, 1'b0, 1'b1);
      repeat (9) step();
      mcand = 32'd3; mplier = 32'd3; start = 1'b1;
      step();
      start = 1'b0;
      wait_done("start_busy");

      step();
      for (int i = 0; i < 5; i++) begin
         check("idle_alu_a", 64'(alu_a), 64'd0);
         check("idle_alu_b", 64'(alu_b), 64'd0);
         check("idle_alu_op", 64'(alu_op), 64'd0);
         check("idle_hold_hi", 64'(hi), 64'(last_prod[63:32]));
         check("idle_hold_lo", 64'(lo), 64'(last_prod[31:0]));
         step();
      end

      issue(32'd9, 32'd9, 1'b0, 1'b0);
      repeat (10) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      seen = 0;
      repeat (40) begin
         step();
         if (done) seen++;
      end
      check("abort_no_done", 64'(seen), 64'd0);

      issue(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1);
      wait_done("neg_x_pos");
      step();
      issue(32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 1'b1);
      wait_done("neg_x_neg");
      issue(32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1);
      wait_done("sgn0_unsigned");

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_mult_sequencer.md
Name: alu_mult_sequencer

Overview:
- Multi-cycle shift-and-add multiplier controller that borrows the shared 32-bit combinational ALU (A, B, operation -> res) to perform a 32x32 -> 64-bit multiply.
- Sits beside the ALU in the MIPS datapath for MULT/MULTU support. Drives the ALU inputs while busy and captures res each cycle.
- Result is exposed as hi/lo, matching the MIPS HI/LO registers.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- OP_ADD, 3'd2, ALU operation code for addition, driven on alu_op while busy.
- OP_IDLE, 3'd0, ALU operation code driven while not busy.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE or DONE.
- mcand  input  WIDTH  multiplicand, captured on accepted start.
- mplier  input  WIDTH  multiplier, captured on accepted start.
- sgn  input  1  signed-multiply request, captured on accepted start; used only with MULT_SIGNED_EN.
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_op  output  3  to ALU operation.
- alu_res  input  WIDTH  from ALU res (combinational, same cycle).
- busy  output  1  high while the multiply is in progress.
- done  output  1  one-cycle pulse when hi/lo become valid.
- hi  output  WIDTH  upper product word.
- lo  output  WIDTH  lower product word.

Behaviour:
- Reset (synchronous, active-high) clears everything:
  - state = IDLE; busy, done = 0; hi, lo = 0; count = 0.
  - alu_a, alu_b = 0; alu_op = OP_IDLE.
  - Reset asserted mid-multiply aborts it: no done pulse, hi/lo = 0 on the next cycle.
- States: IDLE, RUN, (FIX with macro), DONE.
- IDLE, start=1 at edge T:
  - Load hi = 0, lo = mplier, mreg = mcand, count = 0.
  - Go to RUN; busy = 1 from T.
- RUN, one cycle per bit:
  - Drive alu_a = hi, alu_b = lo[0] ? mreg : 0, alu_op = OP_ADD.
  - carry = (alu_res < hi) unsigned. This is 0 when alu_b = 0.
  - At the edge: {hi, lo} <= {carry, alu_res, lo[WIDTH-1:1]}; count++.
- After WIDTH RUN cycles (count == WIDTH-1 at the edge), go to DONE.
  - Unsigned latency: start edge to done-high edge = WIDTH+1 cycles (33 at default).
- DONE, lasts one cycle:
  - done = 1, busy = 0.
  - hi/lo are valid from this cycle and hold until the next accepted start or reset.
  - start=1 in DONE is accepted exactly as from IDLE (back-to-back operation). Otherwise go to IDLE.
- start while busy is ignored. Operands are not re-sampled and the result is unaffected.
- Outside RUN, alu_a/alu_b are 0 and alu_op = OP_IDLE, so the ALU is free for the datapath. The external mux selects using busy.
- Arithmetic is modulo 2^(2*WIDTH); the product is exact for all unsigned operands.
- mcand = 0 or mplier = 0 gives hi = lo = 0 with the same fixed latency. There is no early termination.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined:
  - On accepted start with sgn = 1, operands are replaced by their magnitudes (two's-complement negate when MSB = 1; internal logic, not the ALU).
  - neg = mcand[MSB] ^ mplier[MSB] is latched.
  - After RUN, the FIX state (1 cycle) negates {hi, lo} as a 2*WIDTH-bit value when neg = 1, then goes to DONE.
  - Signed latency = WIDTH+2 cycles. busy stays high through FIX.
  - sgn = 0 behaves as unsigned, still passes through FIX with no change, latency WIDTH+2.
- Undefined: sgn is ignored, FIX does not exist, all multiplies are unsigned with latency WIDTH+1.

Test Plan:
- Basic unsigned: mcand = 100, mplier = 200, start 1 cycle -> busy for 32 cycles, done pulse at cycle 33, hi = 0, lo = 20000 (0x4E20).
- Carry-out path: mcand = mplier = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001. Check alu_op = 3'd2 every RUN cycle.
- Zero operand and back-to-back:
  - mcand = 0x12345678, mplier = 0 -> hi = lo = 0 at cycle 33.
  - start held in the DONE cycle with 7 x 6 -> second done after a further 33 cycles, lo = 42.
- Start-while-busy and reset:
  - Pulse start with 3 x 3 at cycle 10 of a 5 x 5 multiply -> result lo = 25.
  - New run; reset at cycle 12 -> next cycle state IDLE, busy = 0, hi = lo = 0, no done pulse.
- Idle ALU release: while not busy -> alu_a = alu_b = 0, alu_op = 3'd0. alu_res changes have no effect on hi/lo.
- MULT_SIGNED_EN:
  - sgn = 1, mcand = 0xFFFFFFFD (-3), mplier = 5 -> done at cycle 34, hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
  - sgn = 1, -3 x -5 -> hi = 0, lo = 15.
